// File: rtl/fpu_dp_divider_seq.sv
// Sequential IEEE-754 divider: radix-2 restoring long division, one quotient bit per cycle, RNE rounding.
// Latency MAN_W+4 cycles (normal operands) or 1 cycle via SPECIAL; in_ready only in IDLE, result held until out_ready.
module fpu_dp_divider_seq #(
    parameter  int EXP_W = 11,
    parameter  int MAN_W = 52,
    localparam int WIDTH = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             underflow,
    output logic             div_by_zero,
    output logic             invalid
);
    localparam int EW2   = EXP_W + 2;
    localparam int QW    = MAN_W + 3;
    localparam int RW    = MAN_W + 2;
    localparam int CNT_W = $clog2(MAN_W + 4);
    localparam logic [CNT_W-1:0]      LAST   = CNT_W'(MAN_W + 2);
    localparam logic signed [EW2-1:0] BIAS_S = EW2'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW2-1:0] MAX_S  = EW2'((1 << EXP_W) - 1);
    localparam logic signed [EW2-1:0] ZERO_S = '0;
    localparam logic [WIDTH-1:0]      QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_ROUND, S_SPECIAL, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic                    sign_q, sign_d;
    logic signed [EW2-1:0]   exp_q, exp_d;
    logic [RW-1:0]           rem_q, rem_d;
    logic [MAN_W:0]          div_q, div_d;
    logic [QW-1:0]           quo_q, quo_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]        result_q, result_d;
    logic                    ovf_q, ovf_d, unf_q, unf_d, dbz_q, dbz_d, inv_q, inv_d;

    // Operand classification; denormals count as zero because only the exponent is tested.
    logic             a_sign, b_sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, lt;
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_frac, b_frac;
    logic [MAN_W:0]   ma, mb;
    logic signed [EW2-1:0] adj, e_calc;

    assign a_sign = A[WIDTH-1];
    assign b_sign = B[WIDTH-1];
    assign a_exp  = A[WIDTH-2:MAN_W];
    assign b_exp  = B[WIDTH-2:MAN_W];
    assign a_frac = A[MAN_W-1:0];
    assign b_frac = B[MAN_W-1:0];
    assign a_zero = (a_exp == '0);
    assign b_zero = (b_exp == '0);
    assign a_inf  = (a_exp == '1) && (a_frac == '0);
    assign b_inf  = (b_exp == '1) && (b_frac == '0);
    assign a_nan  = (a_exp == '1) && (a_frac != '0);
    assign b_nan  = (b_exp == '1) && (b_frac != '0);
    assign ma     = {1'b1, a_frac};
    assign mb     = {1'b1, b_frac};
    assign lt     = (ma < mb);
    assign adj    = lt ? {EW2{1'b1}} : ZERO_S;
    assign e_calc = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + BIAS_S + adj;

    logic [RW-1:0] diff;
    logic          ge;
    assign diff = rem_q - {1'b0, div_q};
    assign ge   = (rem_q >= {1'b0, div_q});

    // The integer quotient bit is always 1 after pre-normalisation, so rounding only uses the fraction.
    logic                  sticky, up, carry, quo_int_unused;
    logic [MAN_W-1:0]      frac_r;
    logic signed [EW2-1:0] e_r;
    assign quo_int_unused  = quo_q[QW-1];
    assign sticky          = (rem_q != '0);
    assign up              = quo_q[1] & (quo_q[0] | sticky | quo_q[2]);
    assign {carry, frac_r} = {1'b0, quo_q[QW-2:2]} + (MAN_W+1)'(up);
    assign e_r             = exp_q + $signed(EW2'(carry));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            rem_q    <= '0;
            div_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            dbz_q    <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            rem_q    <= rem_d;
            div_q    <= div_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            dbz_q    <= dbz_d;
            inv_q    <= inv_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        rem_d    = rem_q;
        div_d    = div_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        dbz_d    = dbz_q;
        inv_d    = inv_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d = a_sign ^ b_sign;
                    ovf_d  = 1'b0;
                    unf_d  = 1'b0;
                    dbz_d  = 1'b0;
                    inv_d  = 1'b0;
                    state_d = S_SPECIAL;
                    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                        result_d = QNAN;
                        inv_d    = 1'b1;
                    end else if (b_zero && !a_inf) begin
                        result_d = {a_sign ^ b_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        dbz_d    = 1'b1;
                    end else if (a_inf) begin
                        result_d = {a_sign ^ b_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    end else if (a_zero || b_inf) begin
                        result_d = {a_sign ^ b_sign, {(WIDTH-1){1'b0}}};
                    end else begin
                        exp_d   = e_calc;
                        rem_d   = lt ? {ma, 1'b0} : {1'b0, ma};
                        div_d   = mb;
                        quo_d   = '0;
                        cnt_d   = '0;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                rem_d = (ge ? diff : rem_q) << 1;
                quo_d = {quo_q[QW-2:0], ge};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) state_d = S_ROUND;
            end
            S_ROUND: begin
                if (e_r >= MAX_S) begin
                    result_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    ovf_d    = 1'b1;
                end else if (e_r <= ZERO_S) begin
                    result_d = {sign_q, {(WIDTH-1){1'b0}}};
                    unf_d    = 1'b1;
                end else begin
                    result_d = {sign_q, e_r[EXP_W-1:0], frac_r};
                end
                state_d = S_DONE;
            end
            S_SPECIAL: state_d = S_DONE;
            S_DONE: begin
                if (out_ready) begin
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    dbz_d   = 1'b0;
                    inv_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign result      = result_q;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;
    assign div_by_zero = dbz_q;
    assign invalid     = inv_q;
endmodule

// File: tb/tb_fpu_dp_divider_seq.sv
// Bench for fpu_dp_divider_seq: directed and randomized divisions checked against a real-arithmetic reference.
module tb_fpu_dp_divider_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] A = '0;
    logic [63:0] B = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] result;
    logic        overflow, underflow, div_by_zero, invalid;

    int errors = 0;
    int checks = 0;

    fpu_dp_divider_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow(overflow), .underflow(underflow),
        .div_by_zero(div_by_zero), .invalid(invalid)
    );

    always #5 clk = ~clk;

    // Flags packed as {overflow, underflow, div_by_zero, invalid}.
    function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] r, output logic [3:0] f);
        logic [10:0] ea, eb;
        logic [51:0] fa, fb;
        logic [63:0] bits, qnan;
        logic        s, az, bz, ai, bi, an, bn;
        real         q;
        ea = a[62:52]; eb = b[62:52]; fa = a[51:0]; fb = b[51:0];
        az = (ea == 0); bz = (eb == 0);
        ai = (ea == 11'h7FF) && (fa == 0); bi = (eb == 11'h7FF) && (fb == 0);
        an = (ea == 11'h7FF) && (fa != 0); bn = (eb == 11'h7FF) && (fb != 0);
        s  = a[63] ^ b[63];
        qnan = 64'h7FF8000000000000;
        f = 4'b0000;
        if (an || bn || (az && bz) || (ai && bi)) begin
            r = qnan; f = 4'b0001;
        end else if (bz && !ai) begin
            r = {s, 11'h7FF, 52'd0}; f = 4'b0010;
        end else if (ai) begin
            r = {s, 11'h7FF, 52'd0};
        end else if (az || bi) begin
            r = {s, 63'd0};
        end else begin
            q = $bitstoreal({1'b0, a[62:0]}) / $bitstoreal({1'b0, b[62:0]});
            bits = $realtobits(q);
            if (bits[62:52] == 11'h7FF) begin
                r = {s, 11'h7FF, 52'd0}; f = 4'b1000;
            end else if (bits[62:52] == 0) begin
                r = {s, 63'd0}; f = 4'b0100;
            end else begin
                r = {s, bits[62:0]};
            end
        end
    endfunction

    function automatic logic [63:0] rand_normal(input bit wide);
        logic [10:0] e;
        e = wide ? 11'($urandom_range(1, 2046)) : 11'($urandom_range(960, 1090));
        return {1'($urandom), e, 20'($urandom), 32'($urandom)};
    endfunction

    function automatic logic [63:0] rand_any();
        logic [63:0] v;
        v = rand_normal(1'b0);
        case ($urandom_range(0, 4))
            0: v[62:52] = 11'h000;
            1: begin v[62:52] = 11'h000; v[51:0] = '0; end
            2: begin v[62:52] = 11'h7FF; v[51:0] = '0; end
            3: begin v[62:52] = 11'h7FF; v[0] = 1'b1; end
            default: ;
        endcase
        return v;
    endfunction

    task automatic start_op(input logic [63:0] a, input logic [63:0] b);
        int n;
        n = 0;
        @(negedge clk);
        A = a; B = b; in_valid = 1'b1;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = {$urandom, $urandom};
        B = {$urandom, $urandom};
    endtask

    task automatic wait_result(output logic [63:0] res, output logic [3:0] fl,
                               output int lat, output bit tmo);
        lat = 0;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        tmo = !out_valid;
        res = result;
        fl  = {overflow, underflow, div_by_zero, invalid};
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, output logic [63:0] res,
                          output logic [3:0] fl, output int lat, output bit tmo);
        start_op(a, b);
        wait_result(res, fl, lat, tmo);
    endtask

    task automatic release_out();
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_hs in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        checks++;
        if (result !== 64'd0 || {overflow, underflow, div_by_zero, invalid} !== 4'b0) begin
            errors++; $display("FAIL reset_out result=%h flags=%b want 0/0000", result,
                               {overflow, underflow, div_by_zero, invalid});
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [63:0] va[6], vb[6], vr[6], res;
        logic [3:0]  vf[6], fl;
        bit          calc[6], tmo;
        int          lat;
        va = '{64'h4018000000000000, 64'h3FF0000000000000, 64'h3FF0000000000000,
               64'h0000000000000000, 64'h7FE0000000000000, 64'h0010000000000000};
        vb = '{64'h4000000000000000, 64'h4008000000000000, 64'h0000000000000000,
               64'h0000000000000000, 64'h3FE0000000000000, 64'h4000000000000000};
        vr = '{64'h4008000000000000, 64'h3FD5555555555555, 64'h7FF0000000000000,
               64'h7FF8000000000000, 64'h7FF0000000000000, 64'h0000000000000000};
        vf = '{4'b0000, 4'b0000, 4'b0010, 4'b0001, 4'b1000, 4'b0100};
        calc = '{1, 1, 0, 0, 1, 1};
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], res, fl, lat, tmo);
            checks++;
            if (tmo || res !== vr[i] || fl !== vf[i]) begin
                errors++; $display("FAIL dir[%0d] result=%h flags=%b want %h/%b tmo=%0b",
                                   i, res, fl, vr[i], vf[i], tmo);
            end
            checks++;
            if (calc[i] ? (lat != 56) : (lat < 1 || lat > 2)) begin
                errors++; $display("FAIL dir_lat[%0d] latency=%0d want %s", i, lat,
                                   calc[i] ? "56" : "1..2");
            end
            release_out();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
                {overflow, underflow, div_by_zero, invalid} !== 4'b0) begin
                errors++; $display("FAIL dir_release[%0d] out_valid=%b in_ready=%b flags=%b want 0/1/0000",
                                   i, out_valid, in_ready, {overflow, underflow, div_by_zero, invalid});
            end
        end
    endtask

    task automatic test_random_normal();
        logic [63:0] a, b, res, er;
        logic [3:0]  fl, ef;
        int          lat;
        bit          tmo;
        for (int i = 0; i < 40; i++) begin
            a = rand_normal(i % 4 == 3);
            b = rand_normal(i % 4 == 3);
            model(a, b, er, ef);
            run_op(a, b, res, fl, lat, tmo);
            checks++;
            if (tmo || res !== er || fl !== ef || lat != 56) begin
                errors++; $display("FAIL rnd[%0d] %h/%h result=%h flags=%b lat=%0d want %h/%b/56",
                                   i, a, b, res, fl, lat, er, ef);
            end
            release_out();
        end
    endtask

    task automatic test_random_special();
        logic [63:0] a, b, res, er;
        logic [3:0]  fl, ef;
        int          lat;
        bit          tmo;
        for (int i = 0; i < 30; i++) begin
            a = rand_any();
            b = rand_any();
            model(a, b, er, ef);
            run_op(a, b, res, fl, lat, tmo);
            checks++;
            if (tmo || res !== er || fl !== ef) begin
                errors++; $display("FAIL spc[%0d] %h/%h result=%h flags=%b want %h/%b",
                                   i, a, b, res, fl, er, ef);
            end
            release_out();
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] res, er;
        logic [3:0]  fl, ef;
        int          lat, bad;
        bit          tmo;
        model(64'h4014000000000000, 64'h4008000000000000, er, ef);
        run_op(64'h4014000000000000, 64'h4008000000000000, res, fl, lat, tmo);
        checks++;
        if (tmo || res !== er || fl !== ef) begin
            errors++; $display("FAIL bp_first result=%h flags=%b want %h/%b", res, fl, er, ef);
        end
        @(negedge clk);
        in_valid = 1'b1; A = rand_normal(1'b0); B = rand_normal(1'b0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (result !== er || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL bp_hold unstable_cycles=%0d want 0 (result=%h out_valid=%b in_ready=%b)",
                               bad, result, out_valid, in_ready);
        end
        in_valid = 1'b0;
        release_out();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_calc();
        logic [63:0] a, b, res, er;
        logic [3:0]  fl, ef;
        int          lat, seen;
        bit          tmo;
        start_op(64'h4018000000000000, 64'h4000000000000000);
        repeat (20) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_mid in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        @(negedge clk); rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL rst_ghost out_valid_cycles=%0d want 0", seen);
        end
        a = rand_normal(1'b0);
        b = rand_normal(1'b0);
        model(a, b, er, ef);
        run_op(a, b, res, fl, lat, tmo);
        checks++;
        if (tmo || res !== er || fl !== ef || lat != 56) begin
            errors++; $display("FAIL rst_next result=%h flags=%b lat=%0d want %h/%b/56", res, fl, lat, er, ef);
        end
        release_out();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random_normal();
        test_random_special();
        test_backpressure();
        test_reset_mid_calc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
